// File: rtl/mandelbrot_pixel_collector.sv
// mandelbrot_pixel_collector: issues per-pixel engine runs, captures iteration nibbles and streams them as bytes.
// Optional `PIXEL_PACK_EN packs two pixels per byte; otherwise each pixel gets its own byte.
`timescale 1ns/1ps
module mandelbrot_pixel_collector #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       frame_abort,
    output logic       busy,
    output logic       eng_run,
    input  logic       eng_running,
    input  logic       eng_finished,
    input  logic [3:0] eng_ctr,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_sof,
    output logic       m_eol,
    output logic       frame_done,
    output logic       seq_error
);
    localparam int XW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    localparam int HW = HEIGHT > 1 ? $clog2(HEIGHT) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_ARM     = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_CAPTURE = 3'd4;

    logic [2:0]    state;
    logic [XW-1:0] x;
    logic [HW-1:0] y;
    logic          abort_q;
    logic [AW:0]   count;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [9:0]    mem [DEPTH];
    logic          push, pop, room, last_x, last;
    logic          sof_d, eol_d;
    logic [7:0]    px_byte;

    assign last_x = x == XW'(WIDTH - 1);
    assign last   = last_x && y == HW'(HEIGHT - 1);
    // Only one pixel is ever in flight, so free space now is free space at capture.
    assign room   = count < (AW+1)'(DEPTH);
    assign pop    = m_valid && m_ready;
    assign eol_d  = last_x;

`ifdef PIXEL_PACK_EN
    logic [3:0] pack_lo;
    assign push    = state == S_CAPTURE && x[0];
    assign px_byte = {eng_ctr, pack_lo};
    assign sof_d   = x == XW'(1) && y == '0;
`else
    assign push    = state == S_CAPTURE;
    assign px_byte = {4'b0, eng_ctr};
    assign sof_d   = x == '0 && y == '0;
`endif

    assign m_valid = count != '0;
    assign m_data  = mem[rd_ptr][7:0];
    assign m_sof   = m_valid & mem[rd_ptr][9];
    assign m_eol   = m_valid & mem[rd_ptr][8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            x          <= '0;
            y          <= '0;
            abort_q    <= 1'b0;
            busy       <= 1'b0;
            eng_run    <= 1'b0;
            frame_done <= 1'b0;
            seq_error  <= 1'b0;
`ifdef PIXEL_PACK_EN
            pack_lo    <= '0;
`endif
        end else begin
            eng_run    <= 1'b0;
            frame_done <= 1'b0;
            if (busy && frame_abort) abort_q <= 1'b1;
            case (state)
                S_IDLE: if (frame_start && !frame_done) begin
                    x         <= '0;
                    y         <= '0;
                    seq_error <= 1'b0;
                    abort_q   <= 1'b0;
                    busy      <= 1'b1;
                    state     <= S_ISSUE;
`ifdef PIXEL_PACK_EN
                    pack_lo   <= '0;
`endif
                end
                S_ISSUE: if (abort_q) begin
                    busy    <= 1'b0;
                    abort_q <= 1'b0;
                    state   <= S_IDLE;
                end else if (room) begin
                    eng_run <= 1'b1;
                    state   <= S_ARM;
                end
                S_ARM:  if (eng_running) state <= S_WAIT;
                S_WAIT: if (!eng_running) state <= S_CAPTURE;
                S_CAPTURE: begin
`ifdef PIXEL_PACK_EN
                    if (!x[0]) pack_lo <= eng_ctr;
`endif
                    x <= last_x ? '0 : x + 1'b1;
                    if (last_x) y <= y + 1'b1;
                    if (last) begin
                        seq_error  <= seq_error | ~eng_finished;
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        abort_q    <= 1'b0;
                        state      <= S_IDLE;
                    end else begin
                        if (eng_finished) seq_error <= 1'b1;
                        if (abort_q || frame_abort) begin
                            busy    <= 1'b0;
                            abort_q <= 1'b0;
                            state   <= S_IDLE;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {sof_d, eol_d, px_byte};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_mandelbrot_pixel_collector.sv
// tb_mandelbrot_pixel_collector: directed table-driven bench with a small engine model, WIDTH=4 HEIGHT=2 DEPTH=2.
`timescale 1ns/1ps
module tb_mandelbrot_pixel_collector;
    localparam int W = 4;
    localparam int H = 2;
    localparam int D = 2;

    typedef struct {
        logic [7:0] data;
        logic       sof;
        logic       eol;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_start = 1'b0;
    logic       frame_abort = 1'b0;
    logic       m_ready = 1'b1;
    logic       err_mode = 1'b0;
    logic       busy, eng_run, m_valid, m_sof, m_eol, frame_done, seq_error;
    logic [7:0] m_data;
    logic       eng_running, eng_finished;
    logic [3:0] eng_ctr;
    int         pix, cnt_dn;
    int         run_cnt = 0;
    int         done_cnt = 0;
    logic [9:0] got[$];
    int         errors = 0;
    int         checks = 0;
    vec_t       exp_tab[8];
    int         nb, stall_runs, abort_bytes;

    always #5 clk = ~clk;

    mandelbrot_pixel_collector #(.WIDTH(W), .HEIGHT(H), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .frame_abort(frame_abort),
        .busy(busy), .eng_run(eng_run), .eng_running(eng_running), .eng_finished(eng_finished),
        .eng_ctr(eng_ctr), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_sof(m_sof), .m_eol(m_eol), .frame_done(frame_done), .seq_error(seq_error)
    );

    // Engine model: running rises the cycle after eng_run, lasts 3 cycles, reports the pixel index.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_running  <= 1'b0;
            eng_finished <= 1'b0;
            eng_ctr      <= '0;
            pix          <= 0;
            cnt_dn       <= 0;
        end else if (frame_start && !busy) begin
            pix          <= 0;
            eng_finished <= 1'b0;
        end else if (eng_run) begin
            eng_running <= 1'b1;
            cnt_dn      <= 3;
        end else if (eng_running) begin
            if (cnt_dn == 1) begin
                eng_running  <= 1'b0;
                eng_ctr      <= 4'(pix);
                eng_finished <= (pix == 7) || (err_mode && pix == 5);
                pix          <= pix + 1;
            end else begin
                cnt_dn <= cnt_dn - 1;
            end
        end
    end

    always @(posedge clk) begin
        if (eng_run) run_cnt <= run_cnt + 1;
        if (frame_done) done_cnt <= done_cnt + 1;
        if (m_valid && m_ready) got.push_back({m_sof, m_eol, m_data});
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic start_frame();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, " idle timeout"}, int'(busy), 0);
        repeat (10) @(negedge clk);
    endtask

    task automatic check_bytes(input string name, input int base, input int n);
        check({name, " byte count"}, got.size() - base, n);
        for (int i = 0; i < n; i++)
            if (base + i < got.size())
                check($sformatf("%s byte%0d {sof,eol,data}", name, i), int'(got[base + i]),
                      int'({exp_tab[i].sof, exp_tab[i].eol, exp_tab[i].data}));
    endtask

    initial begin
        int base, r0, d0, n;
`ifdef PIXEL_PACK_EN
        nb = 4; stall_runs = 4; abort_bytes = 1;
        exp_tab[0] = '{8'h10, 1'b1, 1'b0};
        exp_tab[1] = '{8'h32, 1'b0, 1'b1};
        exp_tab[2] = '{8'h54, 1'b0, 1'b0};
        exp_tab[3] = '{8'h76, 1'b0, 1'b1};
        exp_tab[4] = '{8'h00, 1'b0, 1'b0};
        exp_tab[5] = '{8'h00, 1'b0, 1'b0};
        exp_tab[6] = '{8'h00, 1'b0, 1'b0};
        exp_tab[7] = '{8'h00, 1'b0, 1'b0};
`else
        nb = 8; stall_runs = 2; abort_bytes = 3;
        exp_tab[0] = '{8'h00, 1'b1, 1'b0};
        exp_tab[1] = '{8'h01, 1'b0, 1'b0};
        exp_tab[2] = '{8'h02, 1'b0, 1'b0};
        exp_tab[3] = '{8'h03, 1'b0, 1'b1};
        exp_tab[4] = '{8'h04, 1'b0, 1'b0};
        exp_tab[5] = '{8'h05, 1'b0, 1'b0};
        exp_tab[6] = '{8'h06, 1'b0, 1'b0};
        exp_tab[7] = '{8'h07, 1'b0, 1'b1};
`endif
        repeat (3) @(negedge clk);
        check("reset busy", int'(busy), 0);
        check("reset eng_run", int'(eng_run), 0);
        check("reset m_valid", int'(m_valid), 0);
        check("reset m_data", int'(m_data), 0);
        check("reset m_sof", int'(m_sof), 0);
        check("reset m_eol", int'(m_eol), 0);
        check("reset frame_done", int'(frame_done), 0);
        check("reset seq_error", int'(seq_error), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Plain frame, no backpressure
        base = got.size(); r0 = run_cnt; d0 = done_cnt;
        start_frame();
        check("t1 busy after start", int'(busy), 1);
        wait_idle("t1");
        check_bytes("t1", base, nb);
        check("t1 runs", run_cnt - r0, 8);
        check("t1 frame_done", done_cnt - d0, 1);
        check("t1 seq_error", int'(seq_error), 0);

        // Backpressure: FIFO fills, issue stalls, data held
        m_ready = 1'b0;
        base = got.size(); r0 = run_cnt;
        start_frame();
        repeat (50) @(negedge clk);
        check("t2 stalled runs", run_cnt - r0, stall_runs);
        check("t2 m_valid held", int'(m_valid), 1);
        check("t2 head data held", int'(m_data), int'(exp_tab[0].data));
        check("t2 head sof held", int'(m_sof), 1);
        m_ready = 1'b1;
        wait_idle("t2");
        check_bytes("t2", base, nb);
        check("t2 runs", run_cnt - r0, 8);

        // Abort during the third pixel
        base = got.size(); r0 = run_cnt; d0 = done_cnt;
        start_frame();
        n = 0;
        while (run_cnt - r0 < 3 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("t3 third run reached", run_cnt - r0, 3);
        frame_abort = 1'b1;
        @(negedge clk);
        frame_abort = 1'b0;
        wait_idle("t3");
        repeat (30) @(negedge clk);
        check("t3 runs", run_cnt - r0, 3);
        check("t3 frame_done", done_cnt - d0, 0);
        check("t3 busy", int'(busy), 0);
        check_bytes("t3", base, abort_bytes);

        // Early eng_finished sets sticky seq_error
        err_mode = 1'b1;
        base = got.size();
        start_frame();
        wait_idle("t4");
        check("t4 seq_error set", int'(seq_error), 1);
        check_bytes("t4", base, nb);
        repeat (20) @(negedge clk);
        check("t4 seq_error sticky", int'(seq_error), 1);
        err_mode = 1'b0;
        base = got.size();
        start_frame();
        check("t4 seq_error cleared", int'(seq_error), 0);
        wait_idle("t4b");
        check("t4b seq_error", int'(seq_error), 0);
        check_bytes("t4b", base, nb);

        // Asynchronous reset while waiting on the engine with queued bytes
        m_ready = 1'b0;
        start_frame();
        n = 0;
        while (!(m_valid && eng_running) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("t5 reached wait with data", int'(m_valid && eng_running), 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5 rst m_valid", int'(m_valid), 0);
        check("t5 rst busy", int'(busy), 0);
        check("t5 rst eng_run", int'(eng_run), 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_ready = 1'b1;
        @(negedge clk);
        base = got.size(); r0 = run_cnt;
        start_frame();
        wait_idle("t5");
        check_bytes("t5", base, nb);
        check("t5 runs", run_cnt - r0, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
